// File: rtl/rpi_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpi_bus_pkg
// Description : Bank numbers, bank-0 special addresses, FIFO-command bit
//               positions and error-counter helpers for the RPi bus block.
// Revision    : 1.0 - initial release
// ============================================================================
package rpi_bus_pkg;

    localparam int BANK_REGS = 0;
    localparam int BANK_FIFO = 1;

    localparam int OFFSET_WIDTH = 15;

    localparam logic [OFFSET_WIDTH-1:0] ADDR_STATUS = 15'd8;
    localparam logic [OFFSET_WIDTH-1:0] ADDR_COUNT  = 15'd9;
    localparam logic [OFFSET_WIDTH-1:0] ADDR_ERRORS = 15'd10;

    localparam int CLEAR_FIFO_BIT   = 0;
    localparam int CLEAR_ERRORS_BIT = 1;

    localparam int ERR_CNT_WIDTH = 8;

    typedef logic [ERR_CNT_WIDTH-1:0] err_cnt_t;

    function automatic err_cnt_t sat_inc(input err_cnt_t value);
        return (value == '1) ? value : value + err_cnt_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Synchronous first-word-fall-through FIFO on an inferable RAM
//               with a registered head word and overflow/underflow events.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty,
    output logic [LOG2_DEPTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] head_q;
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2_DEPTH:0]   count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_COUNT);
        // A pop on a full FIFO frees the slot the simultaneous push lands in.
        pop_ok    = pop && !clear && !empty;
        push_ok   = push && !clear && (!full || pop_ok);
        overflow  = push && !clear && full && !pop_ok;
        underflow = pop && !clear && empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // RAM port and head register carry no reset so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
        head_q <= mem[rd_ptr_q];
    end

    assign head_data = head_q;
    assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/rpi_bus_register_file_and_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rpi_bus_register_file_and_fifo
// Description : Bus-facing control register file (bank 0) and fabric-to-bus
//               readout FIFO (bank 1) with registered readback.
// Revision    : 1.0 - initial release
// ============================================================================
module rpi_bus_register_file_and_fifo
    import rpi_bus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH              = 32,
    parameter int LOG2_OF_NUMBER_OF_REGISTERS = 3,
    parameter int LOG2_OF_FIFO_DEPTH          = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [1:0]                    write_strobe,
    input  logic [1:0]                    read_strobe,
    input  logic [15:0]                   address_word,
    input  logic [BUS_DATA_WIDTH-1:0]     write_data_word,
    output logic [BUS_DATA_WIDTH-1:0]     read_data_word,
    output logic [(2**LOG2_OF_NUMBER_OF_REGISTERS)*BUS_DATA_WIDTH-1:0] control_registers,
    input  logic [BUS_DATA_WIDTH-1:0]     status_word,
    input  logic                          fifo_push,
    input  logic [BUS_DATA_WIDTH-1:0]     fifo_data_in,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [LOG2_OF_FIFO_DEPTH:0]   fifo_count,
    output logic [ERR_CNT_WIDTH-1:0]      overflow_errors,
    output logic [ERR_CNT_WIDTH-1:0]      underflow_errors
);

    localparam int NUM_REGS = 2 ** LOG2_OF_NUMBER_OF_REGISTERS;
    localparam int RA       = LOG2_OF_NUMBER_OF_REGISTERS;

    logic [BUS_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [BUS_DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                      strobe_prev_q;
    err_cnt_t                  overflow_q, overflow_d;
    err_cnt_t                  underflow_q, underflow_d;

    logic [OFFSET_WIDTH-1:0]   offset;
    logic                      reg_hit;
    logic                      fifo_cmd;
    logic                      fifo_clear;
    logic                      err_clear;
    logic                      fifo_pop;
    logic [BUS_DATA_WIDTH-1:0] fifo_head;
    logic                      fifo_overflow;
    logic                      fifo_underflow;
    logic                      unused_inputs;

    assign offset     = address_word[OFFSET_WIDTH-1:0];
    assign reg_hit    = (offset[OFFSET_WIDTH-1:RA] == '0);
    assign fifo_cmd   = write_strobe[BANK_FIFO] && (offset == '0);
    assign fifo_clear = fifo_cmd && write_data_word[CLEAR_FIFO_BIT];
    assign err_clear  = fifo_cmd && write_data_word[CLEAR_ERRORS_BIT];
    // Only the rising edge of the bank-1 read level consumes a word.
    assign fifo_pop   = read_strobe[BANK_FIFO] && !strobe_prev_q && (offset == '0);
    // Bank-0 reads have no side effects, so its read level is not needed.
    assign unused_inputs = read_strobe[BANK_REGS];

    sync_fifo_fwft #(
        .DATA_WIDTH (BUS_DATA_WIDTH),
        .LOG2_DEPTH (LOG2_OF_FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_data_in),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (fifo_overflow),
        .underflow (fifo_underflow)
    );

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clear) begin
            overflow_d  = '0;
            underflow_d = '0;
        end else begin
            if (fifo_overflow)  overflow_d  = sat_inc(overflow_q);
            if (fifo_underflow) underflow_d = sat_inc(underflow_q);
        end
    end

    always_comb begin
        read_data_d = '0;
        if (address_word[15] == 1'(BANK_FIFO)) begin
            if ((offset == '0) && !fifo_empty) read_data_d = fifo_head;
        end else if (reg_hit) begin
            read_data_d = regs_q[offset[RA-1:0]];
        end else if (offset == ADDR_STATUS) begin
            read_data_d = status_word;
        end else if (offset == ADDR_COUNT) begin
            read_data_d = BUS_DATA_WIDTH'(fifo_count);
        end else if (offset == ADDR_ERRORS) begin
            read_data_d = BUS_DATA_WIDTH'({overflow_q, underflow_q});
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            read_data_q   <= '0;
            strobe_prev_q <= 1'b0;
            overflow_q    <= '0;
            underflow_q   <= '0;
        end else begin
            if (write_strobe[BANK_REGS] && reg_hit) begin
                regs_q[offset[RA-1:0]] <= write_data_word;
            end
            read_data_q   <= read_data_d;
            strobe_prev_q <= read_strobe[BANK_FIFO];
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    generate
        for (genvar n = 0; n < NUM_REGS; n++) begin : g_flatten
            assign control_registers[n*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = regs_q[n];
        end
    endgenerate

    assign read_data_word   = read_data_q;
    assign overflow_errors  = overflow_q;
    assign underflow_errors = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rpi_bus_register_file_and_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rpi_bus_register_file_and_fifo
// Description : Self-checking bench with a FIFO scoreboard and register model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rpi_bus_register_file_and_fifo;

    localparam int W = 32;

    logic           clock = 1'b0;
    logic           reset;
    logic [1:0]     write_strobe;
    logic [1:0]     read_strobe;
    logic [15:0]    address_word;
    logic [W-1:0]   write_data_word;
    logic [W-1:0]   read_data_word;
    logic [8*W-1:0] control_registers;
    logic [W-1:0]   status_word;
    logic           fifo_push;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full;
    logic           fifo_empty;
    logic [4:0]     fifo_count;
    logic [7:0]     overflow_errors;
    logic [7:0]     underflow_errors;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] sb [$];
    logic [W-1:0] mreg [8];
    logic [7:0]   exp_over;
    logic [7:0]   exp_under;

    always #5 clock = ~clock;

    rpi_bus_register_file_and_fifo dut (
        .clock             (clock),
        .reset             (reset),
        .write_strobe      (write_strobe),
        .read_strobe       (read_strobe),
        .address_word      (address_word),
        .write_data_word   (write_data_word),
        .read_data_word    (read_data_word),
        .control_registers (control_registers),
        .status_word       (status_word),
        .fifo_push         (fifo_push),
        .fifo_data_in      (fifo_data_in),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_count        (fifo_count),
        .overflow_errors   (overflow_errors),
        .underflow_errors  (underflow_errors)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic bank, input logic [14:0] off, input logic [W-1:0] d);
        address_word    = {bank, off};
        write_data_word = d;
        write_strobe    = bank ? 2'b10 : 2'b01;
        tick();
        write_strobe    = 2'b00;
    endtask

    task automatic read_addr(input logic [15:0] addr, output logic [W-1:0] got);
        address_word = addr;
        tick();
        got = read_data_word;
    endtask

    task automatic push_word(input logic [W-1:0] d);
        fifo_push    = 1'b1;
        fifo_data_in = d;
        if (sb.size() < 16) sb.push_back(d);
        else if (exp_over != 8'hFF) exp_over++;
        tick();
        fifo_push = 1'b0;
    endtask

    // Model side of a pop; returns the word the bus should see.
    task automatic model_pop(output logic [W-1:0] exp);
        if (sb.size() > 0) exp = sb.pop_front();
        else begin
            exp = '0;
            if (exp_under != 8'hFF) exp_under++;
        end
    endtask

    // Rising edge on read_strobe[1], held 5 cycles, then released.
    task automatic pop_strobe(output logic [W-1:0] got);
        address_word   = 16'h8000;
        read_strobe[1] = 1'b1;
        tick();
        got = read_data_word;
        repeat (4) tick();
        read_strobe[1] = 1'b0;
        tick();
    endtask

    task automatic clear_all();
        bus_write(1'b1, 15'd0, 32'h3);
        sb.delete();
        exp_over  = 8'h00;
        exp_under = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (read_data_word !== '0 || control_registers !== '0) begin
            n_bad++;
            $display("FAIL reset_regs: read_data=%h regs=%h, required 0", read_data_word, control_registers);
        end
        n_cmp++;
        if (fifo_count !== 5'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fifo: count=%0d empty=%b full=%b, required 0/1/0", fifo_count, fifo_empty, fifo_full);
        end
        n_cmp++;
        if (overflow_errors !== 8'd0 || underflow_errors !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_errs: ovf=%0d udf=%0d, required 0/0", overflow_errors, underflow_errors);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_registers();
        logic [W-1:0]   got;
        logic [8*W-1:0] flat;
        for (int i = 0; i < 8; i++) begin
            mreg[i] = (i == 3) ? 32'h12345678 : (32'hA5C30000 | 32'(i * 257));
            bus_write(1'b0, 15'(i), mreg[i]);
        end
        n_cmp++;
        if (control_registers[3*W +: W] !== 32'h12345678) begin
            n_bad++;
            $display("FAIL reg3_write: got %h, required 12345678", control_registers[3*W +: W]);
        end
        for (int i = 0; i < 8; i++) begin
            read_addr(16'(i), got);
            n_cmp++;
            if (got !== mreg[i]) begin
                n_bad++;
                $display("FAIL reg_readback[%0d]: got %h, required %h", i, got, mreg[i]);
            end
        end
        // Bank-0 writes above the register range must not alias onto registers.
        bus_write(1'b0, 15'd8, 32'hFFFFFFFF);
        bus_write(1'b0, 15'd12, 32'hFFFFFFFF);
        for (int i = 0; i < 8; i++) flat[i*W +: W] = mreg[i];
        n_cmp++;
        if (control_registers !== flat) begin
            n_bad++;
            $display("FAIL reg_ignore_high: got %h, required %h", control_registers, flat);
        end
    endtask

    task automatic test_readback_map();
        logic [W-1:0] got;
        clear_all();
        status_word = 32'hCAFEF00D;
        push_word(32'h0000BEEF);
        push_word(32'h00001234);
        repeat (2) tick();
        read_addr(16'd8, got);
        n_cmp++;
        if (got !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL map_status: got %h, required cafef00d", got);
        end
        read_addr(16'd9, got);
        n_cmp++;
        if (got !== 32'(sb.size())) begin
            n_bad++;
            $display("FAIL map_count: got %h, required %h", got, 32'(sb.size()));
        end
        read_addr(16'd10, got);
        n_cmp++;
        if (got !== {16'h0, exp_over, exp_under}) begin
            n_bad++;
            $display("FAIL map_errors: got %h, required %h", got, {16'h0, exp_over, exp_under});
        end
        read_addr(16'd11, got);
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL map_unused: got %h, required 0", got);
        end
        read_addr(16'h8001, got);
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL map_bank1_addr1: got %h, required 0", got);
        end
        read_addr(16'h8000, got);
        n_cmp++;
        if (got !== sb[0]) begin
            n_bad++;
            $display("FAIL map_head_peek: got %h, required %h", got, sb[0]);
        end
    endtask

    task automatic test_fifo_order();
        logic [W-1:0] got, exp;
        clear_all();
        push_word(32'hA);
        push_word(32'hB);
        push_word(32'hC);
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            model_pop(exp);
            pop_strobe(got);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL order_pop[%0d]: got %h, required %h", i, got, exp);
            end
        end
        n_cmp++;
        if (fifo_count !== 5'd0 || underflow_errors !== exp_under) begin
            n_bad++;
            $display("FAIL order_final: count=%0d udf=%0d, required 0/%0d", fifo_count, underflow_errors, exp_under);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] got, exp;
        clear_all();
        for (int i = 0; i < 17; i++) push_word(32'h100 + 32'(i));
        repeat (2) tick();
        n_cmp++;
        if (fifo_full !== 1'b1 || fifo_count !== 5'd16 || overflow_errors !== exp_over) begin
            n_bad++;
            $display("FAIL ovf_state: full=%b count=%0d ovf=%0d, required 1/16/%0d", fifo_full, fifo_count, overflow_errors, exp_over);
        end
        for (int i = 0; i < 16; i++) begin
            model_pop(exp);
            pop_strobe(got);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL ovf_drain[%0d]: got %h, required %h", i, got, exp);
            end
        end
        n_cmp++;
        if (fifo_empty !== 1'b1 || underflow_errors !== exp_under) begin
            n_bad++;
            $display("FAIL ovf_17th_absent: empty=%b udf=%0d, required 1/%0d", fifo_empty, underflow_errors, exp_under);
        end
    endtask

    task automatic test_underflow_saturate();
        logic [W-1:0] got, exp;
        int bad_reads;
        clear_all();
        bad_reads = 0;
        for (int i = 0; i < 300; i++) begin
            model_pop(exp);
            pop_strobe(got);
            if (got !== exp) bad_reads++;
        end
        n_cmp++;
        if (bad_reads != 0) begin
            n_bad++;
            $display("FAIL udf_reads: %0d empty reads nonzero, required 0", bad_reads);
        end
        n_cmp++;
        if (underflow_errors !== exp_under || exp_under !== 8'hFF) begin
            n_bad++;
            $display("FAIL udf_saturate: got %0d, required %0d", underflow_errors, exp_under);
        end
        bus_write(1'b1, 15'd0, 32'h2);
        exp_under = 8'h00;
        n_cmp++;
        if (underflow_errors !== 8'd0) begin
            n_bad++;
            $display("FAIL err_clear: udf=%0d, required 0", underflow_errors);
        end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] got, exp, last;
        clear_all();
        for (int i = 0; i < 16; i++) push_word(32'h200 + 32'(i));
        repeat (2) tick();
        address_word   = 16'h8000;
        read_strobe[1] = 1'b1;
        fifo_push      = 1'b1;
        fifo_data_in   = 32'hFEEDFACE;
        model_pop(exp);
        sb.push_back(32'hFEEDFACE);
        tick();
        got       = read_data_word;
        fifo_push = 1'b0;
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL fullpp_head: got %h, required %h", got, exp);
        end
        n_cmp++;
        if (fifo_count !== 5'd16 || overflow_errors !== exp_over) begin
            n_bad++;
            $display("FAIL fullpp_count: count=%0d ovf=%0d, required 16/%0d", fifo_count, overflow_errors, exp_over);
        end
        repeat (4) tick();
        read_strobe[1] = 1'b0;
        tick();
        last = '0;
        for (int i = 0; i < 16; i++) begin
            model_pop(exp);
            pop_strobe(got);
            last = got;
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL fullpp_drain[%0d]: got %h, required %h", i, got, exp);
            end
        end
        n_cmp++;
        if (last !== 32'hFEEDFACE) begin
            n_bad++;
            $display("FAIL fullpp_last: got %h, required feedface", last);
        end
    endtask

    task automatic test_clear_with_push();
        logic [W-1:0] got, exp;
        clear_all();
        for (int i = 0; i < 5; i++) push_word(32'h300 + 32'(i));
        fifo_push    = 1'b1;
        fifo_data_in = 32'h0BADBAD0;
        bus_write(1'b1, 15'd0, 32'h1);
        fifo_push = 1'b0;
        sb.delete();
        n_cmp++;
        if (fifo_count !== 5'd0 || fifo_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_push: count=%0d empty=%b, required 0/1", fifo_count, fifo_empty);
        end
        push_word(32'h00C0FFEE);
        repeat (2) tick();
        model_pop(exp);
        pop_strobe(got);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL clear_then_use: got %h, required %h", got, exp);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] got, exp;
        push_word(32'h411);
        push_word(32'h422);
        push_word(32'h433);
        reset = 1'b1;
        tick();
        n_cmp++;
        if (fifo_count !== 5'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 || control_registers !== '0) begin
            n_bad++;
            $display("FAIL midop_reset: count=%0d empty=%b full=%b, required 0/1/0 with regs 0", fifo_count, fifo_empty, fifo_full);
        end
        reset = 1'b0;
        sb.delete();
        exp_over  = 8'h00;
        exp_under = 8'h00;
        tick();
        push_word(32'h555);
        repeat (2) tick();
        model_pop(exp);
        pop_strobe(got);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL midop_discard: got %h, required %h", got, exp);
        end
    endtask

    initial begin
        reset           = 1'b1;
        write_strobe    = 2'b00;
        read_strobe     = 2'b00;
        address_word    = 16'h0;
        write_data_word = '0;
        status_word     = '0;
        fifo_push       = 1'b0;
        fifo_data_in    = '0;
        exp_over        = 8'h00;
        exp_under       = 8'h00;
        for (int i = 0; i < 8; i++) mreg[i] = '0;

        test_reset();
        test_registers();
        test_readback_map();
        test_fifo_order();
        test_overflow();
        test_underflow_saturate();
        test_full_push_pop();
        test_clear_with_push();
        test_reset_midop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
